// File: rtl/sort_window_ctrl_pkg.sv
// Shared types and default constants for the temporal sort window sequencer.
package sort_ctrl_pkg;

   // Default encoding range: values 0..MAX_T, plus GUARD idle cycles before close.
   localparam int MAX_T = 63;
   localparam int GUARD = 5;

   // Last window cycle index; the window lasts T_END+1 cycles.
   localparam int T_END = MAX_T + GUARD;

   // Timestamp width wide enough to hold 0..T_END.
   localparam int TW = $clog2(T_END + 1);

   // Timestamp reported for a sorted line that never rose inside the window.
   localparam logic [TW-1:0] SENTINEL = {TW{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      READ
   } state_t;

endpackage : sort_ctrl_pkg

// File: rtl/sort_window_ctrl_edge_capture.sv
// Per-line first-rise timestamp capture for the sorter outputs.
// Each line latches the window time of its first observed 1, once per window.
module edge_capture #(
   parameter int N  = 32,
   parameter int TW = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    sorted_out,
   input  logic [TW-1:0]   t_q,
   input  logic            en,
   input  logic            clr,
   input  logic            close,
   output logic [N*TW-1:0] cap_flat
);

   logic [N-1:0] seen;

   // Latch the first rise time of each line; lines still low at close get the sentinel.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the capture array is reset too, so out_time reads 0 after reset
      // instead of stale contents from a previous window.
      if (!rst_n) begin
         seen     <= '0;
         cap_flat <= '0;
      end else if (clr) begin
         seen <= '0;
      end else if (en) begin
         for (int k = 0; k < N; k++) begin
            if (sorted_out[k] && !seen[k]) begin
               cap_flat[k*TW +: TW] <= t_q;
               seen[k]              <= 1'b1;
            end else if (close && !seen[k]) begin
               cap_flat[k*TW +: TW] <= {TW{1'b1}};
            end
         end
      end
   end

endmodule : edge_capture

// File: rtl/sort_window_ctrl.sv
// Sequencer for a temporal bitonic sorter: loads N values, turns each into a
// 0->1 edge during one window (larger value = earlier edge), timestamps the
// sorter outputs, then streams the N timestamps out in sorted-line order.
module sort_window_ctrl #(
   parameter int N     = 32,
   parameter int VW    = 6,
   parameter int MAX_T = sort_ctrl_pkg::MAX_T,
   parameter int GUARD = sort_ctrl_pkg::GUARD,
   parameter int TW    = $clog2(MAX_T + GUARD + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [VW-1:0]        in_data,
   output logic [N-1:0]         raw_in,
   input  logic [N-1:0]         sorted_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_idx,
   output logic [TW-1:0]        out_time,
   output logic                 busy,
   output logic                 done
);

   import sort_ctrl_pkg::*;

   localparam int IW     = $clog2(N);
   localparam int LAST_T = MAX_T + GUARD;

   state_t               state;
   logic [IW-1:0]        idx;
   logic [TW-1:0]        t_q;
   logic [N-1:0][VW-1:0] val;
   logic [VW-1:0]        sat_data;
   logic [N-1:0]         raw_next;
   logic [N*TW-1:0]      cap_flat;
   logic                 in_fire;
   logic                 out_fire;
   logic                 load_last;
   logic                 run_last;
   logic                 read_last;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign load_last = (state == LOAD) && in_fire && (idx == IW'(N - 1));
   assign run_last  = (state == RUN) && (t_q == TW'(LAST_T));
   assign read_last = (state == READ) && out_fire && (idx == IW'(N - 1));

   // Clamp out-of-range input values to the largest encodable value.
   always_comb begin
      // NOTE: every combinational output gets a value before any branch,
      // so no path can leave it unassigned and infer a latch.
      sat_data = in_data;
      if (int'(in_data) > MAX_T) sat_data = VW'(MAX_T);
   end

   // Edge lines for the next window cycle: value v is high once time exceeds MAX_T - v.
   always_comb begin
      raw_next = '0;
      for (int j = 0; j < N; j++) begin
         raw_next[j] = (int'(t_q) + 1) > (MAX_T - int'(val[j]));
      end
   end

   // Main sequencer: load, run the window, read out; abort wins over everything.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         t_q       <= '0;
         val       <= '0;
         raw_in    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         idx       <= '0;
         t_q       <= '0;
         raw_in    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  idx      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (in_fire) begin
                  val[idx] <= sat_data;
                  if (load_last) begin
                     state    <= RUN;
                     idx      <= '0;
                     t_q      <= '0;
                     raw_in   <= '0;
                     in_ready <= 1'b0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            RUN: begin
               if (run_last) begin
                  state     <= READ;
                  idx       <= '0;
                  raw_in    <= '0;
                  out_valid <= 1'b1;
               end else begin
                  t_q    <= t_q + TW'(1);
                  raw_in <= raw_next;
               end
            end
            READ: begin
               if (out_fire) begin
                  if (read_last) begin
                     state     <= IDLE;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output view of the capture array, forced to zero outside READ.
   assign out_idx  = out_valid ? idx : '0;
   assign out_time = out_valid ? cap_flat[idx*TW +: TW] : '0;

   edge_capture #(
      .N  (N),
      .TW (TW)
   ) u_edge_capture (
      .clk        (clk),
      .rst_n      (rst_n),
      .sorted_out (sorted_out),
      .t_q        (t_q),
      .en         ((state == RUN) && !abort),
      .clr        (load_last && !abort),
      .close      (run_last),
      .cap_flat   (cap_flat)
   );

endmodule : sort_window_ctrl

// File: tb/tb_sort_window_ctrl.sv
// Directed bench for sort_window_ctrl with a behavioural ascending sorter.
module tb_sort_window_ctrl;

   localparam int N    = 32;
   localparam int VW   = 7;   // one spare bit so values above MAX_T can be driven
   localparam int MAXT = 63;
   localparam int GD   = 5;
   localparam int TWB  = 7;
   localparam int IW   = 5;
   localparam int LAST = MAXT + GD;
   localparam int LATENCY = N + (LAST + 1) + N;  // 133 edges from start sample to done

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           start     = 1'b0;
   logic           abort     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           out_ready = 1'b0;
   logic [VW-1:0]  in_data   = '0;
   logic           in_ready;
   logic           out_valid;
   logic           busy;
   logic           done;
   logic [N-1:0]   raw_in;
   logic [N-1:0]   sorted_out;
   logic [IW-1:0]  out_idx;
   logic [TWB-1:0] out_time;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int start_cyc;
   int done_cyc;
   bit completed;

   int vals     [N];
   int rise     [N];
   int got_time [N];
   int exp_time [N];
   int ref_time [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Ascending temporal sorter: output k is high once more than k inputs are high.
   always_comb begin
      int ones;
      ones       = 0;
      sorted_out = '0;
      for (int j = 0; j < N; j++) ones += int'(raw_in[j]);
      for (int k = 0; k < N; k++) sorted_out[k] = (ones > k);
   end

   sort_window_ctrl #(
      .N     (N),
      .VW    (VW),
      .MAX_T (MAXT),
      .GUARD (GD),
      .TW    (TWB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .raw_in     (raw_in),
      .sorted_out (sorted_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_time   (out_time),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected rise time of value j and the sorted timestamp list.
   task automatic build_expected();
      int r [N];
      int tmp;
      for (int j = 0; j < N; j++) r[j] = MAXT - ((vals[j] > MAXT) ? MAXT : vals[j]) + 1;
      for (int a = 0; a < N - 1; a++)
         for (int b = 0; b < N - 1 - a; b++)
            if (r[b] > r[b+1]) begin
               tmp = r[b]; r[b] = r[b+1]; r[b+1] = tmp;
            end
      for (int k = 0; k < N; k++) exp_time[k] = r[k];
   endtask

   // One start/load/run/read pass; abort_t >= 0 aborts at that window cycle,
   // rst_k >= 0 asserts reset just before read index rst_k is transferred.
   task automatic run_case(input int abort_t, input int rst_k, input bit gaps);
      int i, k, budget, sat;
      bit fire, prev_stall;
      logic [IW-1:0]  p_idx;
      logic [TWB-1:0] p_time;
      completed = 1'b0;
      for (int j = 0; j < N; j++) rise[j] = -1;
      build_expected();

      start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
      check("load_ready", in_ready, 1);
      check("busy_on", busy, 1);

      i = 0; budget = 0;
      while (i < N && budget < 2000) begin
         in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         in_data  = VW'(vals[i]);
         fire     = in_valid && in_ready;
         @(posedge clk); #1;
         budget++;
         if (fire) i++;
      end
      in_valid = 1'b0;
      if (i < N) begin
         check("load_timeout", i, N);
         return;
      end
      check("run_ready_low", in_ready, 0);

      for (int t = 0; t <= LAST; t++) begin
         for (int j = 0; j < N; j++) if (raw_in[j] && rise[j] < 0) rise[j] = t;
         if (t == abort_t) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_raw", raw_in, 0);
            check("abort_busy", busy, 0);
            check("abort_valid", out_valid, 0);
            check("abort_ready", in_ready, 0);
            repeat (3) begin
               check("abort_no_done", done, 0);
               @(posedge clk); #1;
            end
            return;
         end
         @(posedge clk); #1;
      end
      for (int j = 0; j < N; j++) begin
         sat = (vals[j] > MAXT) ? MAXT : vals[j];
         check($sformatf("rise[%0d]", j), rise[j], MAXT - sat + 1);
      end
      check("read_raw_clear", raw_in, 0);
      check("read_valid", out_valid, 1);

      k = 0; budget = 0; prev_stall = 1'b0;
      while (k < N && budget < 2000) begin
         if (k == rst_k) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_raw", raw_in, 0);
            check("rst_idx", out_idx, 0);
            check("rst_time", out_time, 0);
            check("rst_done", done, 0);
            out_ready = 1'b0;
            start     = 1'b1;
            @(posedge clk); #1;
            check("rst_start_ignored", busy, 0);
            start = 1'b0;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_idle_busy", busy, 0);
            check("rst_idle_ready", in_ready, 0);
            return;
         end
         out_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (prev_stall) begin
            check("hold_idx", out_idx, p_idx);
            check("hold_time", out_time, p_time);
         end
         check("out_idx", out_idx, k);
         fire = out_valid && out_ready;
         if (fire) got_time[k] = int'(out_time);
         prev_stall = out_valid && !out_ready;
         p_idx      = out_idx;
         p_time     = out_time;
         @(posedge clk); #1;
         budget++;
         if (fire) k++;
      end
      out_ready = 1'b0;
      if (k < N) begin
         check("read_timeout", k, N);
         return;
      end
      check("done_pulse", done, 1);
      done_cyc = cyc;
      check("busy_off", busy, 0);
      for (int kk = 0; kk < N; kk++) check($sformatf("time[%0d]", kk), got_time[kk], exp_time[kk]);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      completed = 1'b1;
   endtask

   initial begin
      int ones;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", in_ready, 0);
      check("reset_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_raw", raw_in, 0);
      check("reset_idx", out_idx, 0);
      check("reset_time", out_time, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ascending values 0..31: line k rises at 33+k.
      for (int j = 0; j < N; j++) vals[j] = j;
      run_case(-1, -1, 1'b0);
      check("s1_done", completed, 1);
      check("s1_rise31", rise[31], 33);
      check("s1_rise0", rise[0], 64);
      for (int k = 0; k < N; k++) check($sformatf("s1_time[%0d]", k), got_time[k], 33 + k);
      check("s1_latency", done_cyc - start_cyc, LATENCY);
      for (int k = 0; k < N; k++) ref_time[k] = got_time[k];

      // All values at MAX_T: every line rises together at t=1.
      for (int j = 0; j < N; j++) vals[j] = MAXT;
      run_case(-1, -1, 1'b0);
      check("s2_done", completed, 1);
      for (int k = 0; k < N; k++) check($sformatf("s2_time[%0d]", k), got_time[k], 1);

      // Mixed 70 (saturates), 63 and 0: 22 lines at t=1, 10 at t=64.
      for (int j = 0; j < N; j++) vals[j] = (j % 3 == 0) ? 70 : ((j % 3 == 1) ? MAXT : 0);
      run_case(-1, -1, 1'b0);
      check("s3_done", completed, 1);
      ones = 0;
      for (int k = 0; k < N; k++) if (got_time[k] == 1) ones++;
      check("s3_count_one", ones, 22);
      check("s3_time21", got_time[21], 1);
      check("s3_time22", got_time[22], 64);

      // Random handshake gaps on both sides: same timestamps as the first run.
      for (int j = 0; j < N; j++) vals[j] = j;
      run_case(-1, -1, 1'b1);
      check("s4_done", completed, 1);
      for (int k = 0; k < N; k++) check($sformatf("s4_time[%0d]", k), got_time[k], ref_time[k]);

      // Abort in the middle of the window, then a clean run.
      run_case(20, -1, 1'b0);
      run_case(-1, -1, 1'b0);
      check("s5_done", completed, 1);
      for (int k = 0; k < N; k++) check($sformatf("s5_time[%0d]", k), got_time[k], ref_time[k]);

      // Reset mid-read, then a clean run.
      run_case(-1, 10, 1'b0);
      run_case(-1, -1, 1'b0);
      check("s6_done", completed, 1);
      check("s6_latency", done_cyc - start_cyc, LATENCY);
      for (int k = 0; k < N; k++) check($sformatf("s6_time[%0d]", k), got_time[k], ref_time[k]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Bound on total run time in case a handshake never completes.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_sort_window_ctrl
